shift_seq_ctrl: RTL

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl_if.sv | 38 +++
 rtl/shift_seq_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and shift-register control bundle between upstream, controller and the external shift register.
interface shift_seq_ctrl_if;
    logic tx_valid;
    logic tx_ready;
    logic abort;
    logic sr_clk_en;
    logic sr_shift_load_n;
    logic sr_si;
    logic bit_strobe;
    logic busy;
    logic frame_done;

    // Upstream producer side (also observes the shift-register controls).
    modport master (
        output tx_valid,
        output abort,
        input  tx_ready,
        input  sr_clk_en,
        input  sr_shift_load_n,
        input  sr_si,
        input  bit_strobe,
        input  busy,
        input  frame_done
    );

    // Controller side.
    modport slave (
        input  tx_valid,
        input  abort,
        output tx_ready,
        output sr_clk_en,
        output sr_shift_load_n,
        output sr_si,
        output bit_strobe,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a parallel-load shift register: loads one word on accept, then issues
// NBIT shift pulses spaced CLKDIV clocks apart and flags the end of the frame.
module shift_seq_ctrl #(
    parameter int unsigned NBIT   = 8,
    parameter int unsigned CLKDIV = 4,
    parameter logic        FILL   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    shift_seq_ctrl_if.slave bus
);
    localparam int unsigned BCNT_W = $clog2(NBIT + 1);
    localparam int unsigned DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(NBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    logic tx_ready;
    logic sr_clk_en;
    logic sr_shift_load_n;
    logic bit_strobe;
    logic busy;
    logic frame_done;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next state, counters and the shift-register controls.
    always_comb begin
        state_d         = state_q;
        div_d           = div_q;
        bcnt_d          = bcnt_q;
        tx_ready        = 1'b0;
        sr_clk_en       = 1'b0;
        sr_shift_load_n = 1'b1;
        bit_strobe      = 1'b0;
        busy            = 1'b1;
        frame_done      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (bus.tx_valid && !bus.abort) begin
                    sr_clk_en       = 1'b1;
                    sr_shift_load_n = 1'b0;
                    div_d           = '0;
                    bcnt_d          = '0;
                    state_d         = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    div_d   = '0;
                    bcnt_d  = '0;
                    state_d = IDLE;
                end else if (div_q == DIV_LAST) begin
                    sr_clk_en  = 1'b1;
                    bit_strobe = 1'b1;
                    div_d      = '0;
                    bcnt_d     = bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BIT_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                // Frame end is reported even if abort arrives now; abort only forces IDLE, which is next anyway.
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_ready        = tx_ready;
    assign bus.sr_clk_en       = sr_clk_en;
    assign bus.sr_shift_load_n = sr_shift_load_n;
    assign bus.sr_si           = FILL;
    assign bus.bit_strobe      = bit_strobe;
    assign bus.busy            = busy;
    assign bus.frame_done      = frame_done;
endmodule
